// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states, ALUOp codes.
// ALUOp codes are also consumed by the ALU control block, so keep them in sync there.
// Pure declarations; no logic, no latency.
package mips_multicycle_control_pkg;

    localparam int OPCODE_W = 6;
    localparam int ALUOP_W  = 3;
    localparam int STATE_W  = 4;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'b010;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_WB_MEM    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_WB_ALU    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    // All datapath strobes driven by the control FSM, bundled for the decode sub-module.
    typedef struct packed {
        logic               pc_write;
        logic               pc_write_cond;
        logic               i_or_d;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               ir_write;
        logic [1:0]         pc_source;
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic               reg_write;
        logic               reg_dst;
        logic               instr_done;
    } ctrl_t;

    // True for the opcodes this controller knows how to sequence.
    function automatic logic op_decoded(input logic [OPCODE_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state -> datapath strobe decode (Moore, plus mem_ready-gated strobes).
// Latency: zero, purely combinational.
// Backpressure: mem_ready only gates ir_write/pc_write in FETCH and instr_done in MEM_WRITE.
import mips_multicycle_control_pkg::*;

module mips_ctrl_outdec (
    input  logic   rst_i,
    input  state_t state_i,
    input  logic   mem_ready_i,
    input  logic   decode_nop_i,
    output ctrl_t  ctrl_o
);

    // Decode strobes from the current state; everything defaults to 0 and reset forces all 0.
    always_comb begin
        ctrl_o = '0;
        if (!rst_i) begin
            case (state_i)
                S_FETCH: begin
                    ctrl_o.mem_read  = 1'b1;
                    ctrl_o.alu_src_b = 2'b01;
                    ctrl_o.alu_op    = ALUOP_ADD;
                    ctrl_o.ir_write  = mem_ready_i;
                    ctrl_o.pc_write  = mem_ready_i;
                end
                S_DECODE: begin
                    ctrl_o.alu_src_b  = 2'b11;
                    ctrl_o.alu_op     = ALUOP_ADD;
                    ctrl_o.instr_done = decode_nop_i;
                end
                S_MEM_ADDR, S_ADDI_EXEC: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = 2'b10;
                    ctrl_o.alu_op    = ALUOP_ADD;
                end
                S_MEM_READ: begin
                    ctrl_o.mem_read = 1'b1;
                    ctrl_o.i_or_d   = 1'b1;
                end
                S_WB_MEM: begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.mem_to_reg = 1'b1;
                    ctrl_o.instr_done = 1'b1;
                end
                S_MEM_WRITE: begin
                    ctrl_o.mem_write  = 1'b1;
                    ctrl_o.i_or_d     = 1'b1;
                    ctrl_o.instr_done = mem_ready_i;
                end
                S_EXECUTE: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = 2'b00;
                    ctrl_o.alu_op    = ALUOP_FUNCT;
                end
                S_WB_ALU: begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.reg_dst    = 1'b1;
                    ctrl_o.instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ctrl_o.alu_src_a     = 1'b1;
                    ctrl_o.alu_op        = ALUOP_SUB;
                    ctrl_o.pc_write_cond = 1'b1;
                    ctrl_o.pc_source     = 2'b01;
                    ctrl_o.instr_done    = 1'b1;
                end
                S_JUMP: begin
                    ctrl_o.pc_write   = 1'b1;
                    ctrl_o.pc_source  = 2'b10;
                    ctrl_o.instr_done = 1'b1;
                end
                S_ADDI_WB: begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.instr_done = 1'b1;
                end
                default: ctrl_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main multicycle MIPS control FSM; optional illegal-opcode trap under `ILLEGAL_OP_TRAP_EN.
// Latency (mem_ready=1): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold until mem_ready; other states ignore it.
import mips_multicycle_control_pkg::*;

module mips_multicycle_control (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                ir_write,
    output logic [1:0]          pc_source,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                reg_write,
    output logic                reg_dst,
    output logic [STATE_W-1:0]  state,
    output logic                instr_done,
    output logic                illegal_op
);

    state_t state_q, state_d;
    ctrl_t  ctrl;
    logic   decode_nop;

    // State register; reset is synchronous so the edge after rst lands in FETCH.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state sequencing by state, opcode and mem_ready.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = mem_ready ? S_WB_MEM : S_MEM_READ;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_d = S_WB_ALU;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP:      state_d = S_TRAP;
`endif
            // Writeback/branch/jump states and unused codes all return to FETCH.
            default:     state_d = S_FETCH;
        endcase
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_q;

    // Sticky illegal-opcode flag, set on the DECODE -> TRAP transition.
    always_ff @(posedge clk) begin
        if (rst)                                             illegal_q <= 1'b0;
        else if (state_q == S_DECODE && !op_decoded(opcode)) illegal_q <= 1'b1;
    end

    assign illegal_op = illegal_q & ~rst;
    assign decode_nop = 1'b0;
`else
    assign illegal_op = 1'b0;
    // Unknown opcodes retire in DECODE as a NOP.
    assign decode_nop = (state_q == S_DECODE) && !op_decoded(opcode);
`endif

    mips_ctrl_outdec u_outdec (
        .rst_i        (rst),
        .state_i      (state_q),
        .mem_ready_i  (mem_ready),
        .decode_nop_i (decode_nop),
        .ctrl_o       (ctrl)
    );

    assign state         = rst ? S_FETCH : state_q;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign ir_write      = ctrl.ir_write;
    assign pc_source     = ctrl.pc_source;
    assign alu_op        = ctrl.alu_op;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign instr_done    = ctrl.instr_done;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed-vector bench for the multicycle MIPS control FSM with a decoupled scoreboard.
// Each cycle's expected outputs are queued by the stimulus and checked at the falling edge.
// Covers reset, lw/sw/R/beq/j/addi, memory stalls, mid-instruction reset and illegal opcodes.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write;
    logic [1:0] pc_source, alu_src_b;
    logic [2:0] alu_op;
    logic       alu_src_a, reg_write, reg_dst, instr_done, illegal_op;
    logic [3:0] state;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

    typedef logic [22:0] vec_t;
    vec_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    mips_multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .ir_write(ir_write), .pc_source(pc_source), .alu_op(alu_op),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
        .reg_dst(reg_dst), .state(state), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Expected output vector for one cycle, written straight from the per-state strobe table.
    function automatic vec_t mk(input int st, input bit mr, input bit r, input bit ill, input bit nop);
        logic       pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, m2r = 0, irw = 0;
        logic       asa = 0, rw = 0, rd = 0, dn = 0, il = 0;
        logic [1:0] ps = 0, asb = 0;
        logic [2:0] aop = 0;
        logic [3:0] s = 0;
        if (!r) begin
            s  = st[3:0];
            il = ill;
            case (st)
                0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
                1:  begin asb = 2'b11; dn = nop; end
                2:  begin asa = 1; asb = 2'b10; end
                3:  begin mrd = 1; iod = 1; end
                4:  begin rw = 1; m2r = 1; dn = 1; end
                5:  begin mwr = 1; iod = 1; dn = mr; end
                6:  begin asa = 1; aop = 3'b010; end
                7:  begin rw = 1; rd = 1; dn = 1; end
                8:  begin asa = 1; aop = 3'b001; pwc = 1; ps = 2'b01; dn = 1; end
                9:  begin pw = 1; ps = 2'b10; dn = 1; end
                10: begin asa = 1; asb = 2'b10; end
                11: begin rw = 1; dn = 1; end
                default: ;
            endcase
        end
        return {s, pw, pwc, iod, mrd, mwr, m2r, irw, ps, aop, asa, asb, rw, rd, dn, il};
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show during that cycle.
    task automatic step(input string nm, input bit r, input logic [5:0] op, input bit mr,
                        input int st, input bit ill = 1'b0, input bit nop = 1'b0);
        rst       = r;
        opcode    = op;
        mem_ready = mr;
        exp_q.push_back(mk(st, mr, r, ill, nop));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs against the queued expectation mid-cycle.
    initial begin
        vec_t  e, a;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                a = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
                     ir_write, pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst,
                     instr_done, illegal_op};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got %h want %h", n, a, e);
                end
            end
        end
    end

    initial begin
        int budget;
        rst = 1'b1; opcode = '0; mem_ready = 1'b0;
        @(posedge clk); #1;

        step("reset_a", 1, LW, 1, 0);
        step("reset_b", 1, LW, 0, 0);

        // lw, no stalls: 0,1,2,3,4
        step("lw_fetch",  0, LW, 1, 0);
        step("lw_decode", 0, LW, 1, 1);
        step("lw_addr",   0, LW, 1, 2);
        step("lw_read",   0, LW, 1, 3);
        step("lw_wb",     0, LW, 1, 4);

        // sw with three stall cycles in MEM_WRITE
        step("sw_fetch",  0, SW, 1, 0);
        step("sw_decode", 0, SW, 1, 1);
        step("sw_addr",   0, SW, 1, 2);
        step("sw_wr0",    0, SW, 0, 5);
        step("sw_wr1",    0, SW, 0, 5);
        step("sw_wr2",    0, SW, 0, 5);
        step("sw_wr3",    0, SW, 1, 5);

        // R-type
        step("r_fetch",  0, RT, 1, 0);
        step("r_decode", 0, RT, 1, 1);
        step("r_exec",   0, RT, 1, 6);
        step("r_wb",     0, RT, 1, 7);

        // beq
        step("beq_fetch",  0, BEQ, 1, 0);
        step("beq_decode", 0, BEQ, 1, 1);
        step("beq_branch", 0, BEQ, 1, 8);

        // j with a two-cycle fetch stall
        step("j_fstall0", 0, J, 0, 0);
        step("j_fstall1", 0, J, 0, 0);
        step("j_fetch",   0, J, 1, 0);
        step("j_decode",  0, J, 1, 1);
        step("j_jump",    0, J, 1, 9);

        // addi with mem_ready low where it must be ignored
        step("addi_fetch",  0, ADDI, 1, 0);
        step("addi_decode", 0, ADDI, 0, 1);
        step("addi_exec",   0, ADDI, 0, 10);
        step("addi_wb",     0, ADDI, 0, 11);

        // reset while waiting in MEM_READ
        step("rlw_fetch",  0, LW, 1, 0);
        step("rlw_decode", 0, LW, 1, 1);
        step("rlw_addr",   0, LW, 1, 2);
        step("rlw_read",   0, LW, 0, 3);
        step("rlw_rst",    1, LW, 1, 0);
        step("rlw_after",  0, LW, 0, 0);

        // undecoded opcode
        step("bad_fetch", 0, BAD, 1, 0);
`ifdef ILLEGAL_OP_TRAP_EN
        step("bad_decode", 0, BAD, 1, 1);
        step("bad_trap0",  0, BAD, 1, 12, 1);
        step("bad_trap1",  0, RT,  0, 12, 1);
        step("bad_rst",    1, RT,  1, 0);
        step("bad_clear",  0, RT,  0, 0);
`else
        step("bad_decode", 0, BAD, 1, 1, 0, 1);
        step("bad_nop",    0, BAD, 0, 0);
        step("bad_next",   0, RT,  1, 0);
`endif

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
